// File: rtl/deserializer.sv
// Serial-to-byte receiver: start bit 1, 8 data bits LSB first, stop bit 0, valid/ack holding register.
// Optional `DESERIALIZER_INPUT_SYNC_EN adds a two-flop rxd synchronizer (+2 cycles rxd latency).
module deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t     state, state_nxt;
  logic       rxd_s;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       good, bad, shift_en, cnt_clr;
  logic       take, ackd;

`ifdef DESERIALIZER_INPUT_SYNC_EN
  logic rxd_p0, rxd_p1;

  // Stage p0/p1: synchronizer flops ahead of the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b0;
      rxd_p1 <= 1'b0;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
    end
  end
  assign rxd_s = rxd_p1;
`else
  assign rxd_s = rxd;
`endif

  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    bad       = 1'b0;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rxd_s) begin
          state_nxt = DATA;
          cnt_clr   = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (cnt == 3'd7) state_nxt = STOP;
      end
      STOP: begin
        // A 1 here is a framing error, not a new start bit
        state_nxt = IDLE;
        if (rxd_s) bad  = 1'b1;
        else       good = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ackd = valid & ack;
  assign take = good & (~valid | ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      frame_err <= bad;
      if (cnt_clr)       cnt <= 3'd0;
      else if (shift_en) cnt <= cnt + 3'd1;
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
      if (take) data <= shreg;
      // A load in the same cycle as ack keeps valid high with the new byte
      if (take)      valid <= 1'b1;
      else if (ackd) valid <= 1'b0;
      if (good & valid & ~ack) overrun <= 1'b1;
      else if (ackd)           overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer; expected bytes queued when frames are driven.
module tb_deserializer;

`ifdef DESERIALIZER_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  deserializer dut (
    .clk(clk), .rst(rst), .rxd(rxd), .ack(ack),
    .data(data), .valid(valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int   vec = 0;
  int   miss = 0;
  int   cyc = 0;
  int   ack_at = -1;
  int   fe_cnt = 0;
  logic pv = 1'b0;
  logic pa = 1'b0;
  logic busy_hist [0:1023];
  logic fe_hist   [0:1023];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: observe outputs, drive rxd/ack, advance to #1 after the edge.
  task automatic step(input logic b);
    busy_hist[cyc] = busy;
    fe_hist[cyc]   = frame_err;
    if (frame_err === 1'b1) fe_cnt++;
    // New byte present when valid rises, or valid held across an accepted ack
    if (valid === 1'b1 && (!pv || pa)) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, data}, 32'hFFFF_FFFF);
      else                   chk("data", {24'h0, data}, {24'h0, exp_q.pop_front()});
    end
    pv  = valid;
    rxd = b;
    ack = (cyc == ack_at);
    pa  = ack;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop, output int k);
    k = cyc;
    step(1'b1);
    for (int i = 0; i < 8; i++) step(v[i]);
    step(stop);
    rxd = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i <= LAT; i++) step(1'b0);
  endtask

  task automatic do_ack();
    ack_at = cyc;
    step(1'b0);
  endtask

  initial begin
    int k, k2;

    // Reset state
    rst = 1'b1;
    repeat (3) step(1'b0);
    rst = 1'b0;
    pv = 1'b0; pa = 1'b0;
    chk("rst_data", {24'h0, data}, 32'h00);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    step(1'b0);

    // Good frame 0xA5 with busy window
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, k);
    settle();
    chk("a5_valid", {31'h0, valid}, 32'h1);
    for (int i = 0; i <= 10 + LAT; i++)
      chk("a5_busy", {31'h0, busy_hist[k+i]}, {31'h0, (i >= 1 + LAT && i <= 9 + LAT)});
    do_ack();
    chk("a5_ack_valid", {31'h0, valid}, 32'h0);

    // Frame error on 0x3C
    fe_cnt = 0;
    send_frame(8'h3C, 1'b1, k);
    settle();
    step(1'b0);
    chk("fe_pos", {31'h0, fe_hist[k+10+LAT]}, 32'h1);
    chk("fe_count", fe_cnt, 1);
    chk("fe_valid", {31'h0, valid}, 32'h0);
    chk("fe_data", {24'h0, data}, 32'hA5);
    chk("fe_busy", {31'h0, busy}, 32'h0);

    // Overrun: 0x11 pending, 0x22 dropped
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, k);
    settle();
    send_frame(8'h22, 1'b0, k);
    settle();
    chk("ovr_data", {24'h0, data}, 32'h11);
    chk("ovr_valid", {31'h0, valid}, 32'h1);
    chk("ovr_flag", {31'h0, overrun}, 32'h1);
    do_ack();
    chk("ovr_ack_valid", {31'h0, valid}, 32'h0);
    chk("ovr_ack_flag", {31'h0, overrun}, 32'h0);

    // Same-cycle ack and completion
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, k);
    settle();
    exp_q.push_back(8'h22);
    ack_at = cyc + 9 + LAT;
    send_frame(8'h22, 1'b0, k);
    settle();
    chk("same_valid", {31'h0, valid}, 32'h1);
    chk("same_ovr", {31'h0, overrun}, 32'h0);
    do_ack();
    chk("same_ack_valid", {31'h0, valid}, 32'h0);

    // Reset mid-frame, then 0xFF
    step(1'b1);
    step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    pv = 1'b0; pa = 1'b0;
    chk("mid_rst_data", {24'h0, data}, 32'h00);
    chk("mid_rst_valid", {31'h0, valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("mid_rst_ovr", {31'h0, overrun}, 32'h0);
    fe_cnt = 0;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b0, k);
    settle();
    chk("ff_valid", {31'h0, valid}, 32'h1);
    do_ack();

    // Back-to-back 0x01, 0x80 acking each
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_frame(8'h01, 1'b0, k);
    ack_at = cyc + LAT;
    send_frame(8'h80, 1'b0, k2);
    settle();
    chk("b2b_valid", {31'h0, valid}, 32'h1);
    chk("b2b_ovr", {31'h0, overrun}, 32'h0);
    do_ack();
    step(1'b0);
    chk("b2b_ferr_none", fe_cnt, 0);
    chk("b2b_final_valid", {31'h0, valid}, 32'h0);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
